// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one single-port synchronous RAM.
// Latency: request sampled at edge T, RAM strobe in cycle T+1, ack in cycle T+2.
// Requesters hold req until ack; data is bounded to MAX_DM_RUN grants while a fetch waits.
module mem_port_arbiter #(
  parameter int MAX_DM_RUN = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_sel,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        stall_req
);

  typedef enum logic [2:0] {IDLE, IF_ADDR, IF_DATA, DM_ADDR, DM_DATA} state_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ram_cmd_t;

  localparam logic [2:0] MAX_RUN = 3'(MAX_DM_RUN);

  state_t     state;
  logic [2:0] run_cnt;
  ram_cmd_t   cmd;
  logic       dm_rd;
  logic       grant_dm;
  logic       grant_if;

  assign grant_dm = dm_req && (!if_req || (run_cnt < MAX_RUN));
  assign grant_if = !grant_dm && if_req;

  // The RAM command is captured at the grant edge, so a requester that breaks
  // protocol by dropping req mid-access still gets a clean access and one ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      run_cnt <= 3'd0;
      cmd     <= '0;
      ram_ce  <= 1'b0;
      if_ack  <= 1'b0;
      dm_ack  <= 1'b0;
      dm_rd   <= 1'b0;
    end else begin
      cmd    <= '0;
      ram_ce <= 1'b0;
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IF_ADDR: begin
          state  <= IF_DATA;
          if_ack <= 1'b1;
        end
        DM_ADDR: begin
          state  <= DM_DATA;
          dm_ack <= 1'b1;
          dm_rd  <= !cmd.we;
        end
        IDLE, IF_DATA, DM_DATA: begin
          if (grant_dm) begin
            state  <= DM_ADDR;
            ram_ce <= 1'b1;
            cmd    <= '{we: dm_we, sel: dm_sel, addr: dm_addr, wdata: dm_wdata};
            if (!if_req)
              run_cnt <= 3'd0;
            else if (run_cnt < MAX_RUN)
              run_cnt <= run_cnt + 3'd1;
          end else if (grant_if) begin
            state   <= IF_ADDR;
            ram_ce  <= 1'b1;
            cmd     <= '{we: 1'b0, sel: 4'hF, addr: if_addr, wdata: 32'h0};
            run_cnt <= 3'd0;
          end else begin
            state   <= IDLE;
            run_cnt <= 3'd0;
          end
        end
        default: begin
          state   <= IDLE;
          run_cnt <= 3'd0;
        end
      endcase
    end
  end

  assign ram_we    = cmd.we;
  assign ram_sel   = cmd.sel;
  assign ram_addr  = cmd.addr;
  assign ram_wdata = cmd.wdata;

  assign if_rdata  = if_ack ? ram_rdata : 32'h0;
  assign dm_rdata  = (dm_ack && dm_rd) ? ram_rdata : 32'h0;
  assign stall_req = (if_req & ~if_ack) | (dm_req & ~dm_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous RAM.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [3:0]  dm_sel = 4'h0;
  logic [31:0] dm_addr = 32'h0;
  logic [31:0] dm_wdata = 32'h0;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        ram_ce;
  logic        ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;
  logic        stall_req;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_DM_RUN(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .stall_req(stall_req)
  );

  logic [31:0] mem [0:255];

  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_sel[b]) mem[ram_addr[9:2]][8*b +: 8] = ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[9:2]];
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        ifr;
    logic [31:0] ifa;
    logic        dmr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dma;
    logic [31:0] wd;
    logic        e_ce;
    logic        e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic        e_ia;
    logic [31:0] e_ird;
    logic        e_da;
    logic [31:0] e_drd;
    logic        e_st;
  } vec_t;

  localparam logic [31:0] FA = 32'h0000_0010;
  localparam logic [31:0] DA = 32'h0000_0100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both ports held continuously; ack order follows pat (bit k set = data ack).
  task automatic run_both(input string tag, input int n, input logic [7:0] pat);
    int k = 0;
    if_req = 1'b1; if_addr = FA;
    dm_req = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = DA; dm_wdata = 32'h0;
    for (int c = 0; c < 4 * n + 8 && k < n; c++) begin
      #1;
      chk($sformatf("%s ack_excl c%0d", tag, c), 32'(if_ack & dm_ack), 32'h0);
      chk($sformatf("%s stall c%0d", tag, c), 32'(stall_req), 32'h1);
      if (if_ack || dm_ack) begin
        chk($sformatf("%s order k%0d", tag, k), 32'(dm_ack), 32'(pat[k]));
        chk($sformatf("%s ack_cycle k%0d", tag, k), 32'(c), 32'(2 + 2 * k));
        if (if_ack) chk($sformatf("%s if_rdata k%0d", tag, k), if_rdata, 32'h3401_1100);
        if (dm_ack) chk($sformatf("%s dm_rdata k%0d", tag, k), dm_rdata, 32'h1122_BEEF);
        k++;
        if (k == n) begin
          if_req = 1'b0;
          dm_req = 1'b0;
        end
      end
      tick();
    end
    chk($sformatf("%s acks_seen", tag), 32'(k), 32'(n));
  endtask

  vec_t vecs [19];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4]  = 32'h3401_1100;
    mem[64] = 32'h1122_3344;

    //          rst   ifr   ifa    dmr   we    sel    dma    wd              ce    we    sel    addr   wd              ia    ird             da    drd             st
    vecs[0]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0,          1'b0};
    vecs[1]  = '{1'b0, 1'b1, FA,    1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0,          1'b1};
    vecs[2]  = '{1'b0, 1'b1, FA,    1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b1, 1'b0, 4'hF, FA,    32'h0,          1'b0, 32'h0,          1'b0, 32'h0,          1'b1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b1, 32'h3401_1100,  1'b0, 32'h0,          1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'h3, DA,    32'hDEAD_BEEF,  1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0,          1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'h3, DA,    32'hDEAD_BEEF,  1'b1, 1'b1, 4'h3, DA,    32'hDEAD_BEEF,  1'b0, 32'h0,          1'b0, 32'h0,          1'b1};
    vecs[6]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b0, 32'h0,          1'b1, 32'h0,          1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, DA,    32'hCAFE_F00D,  1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0,          1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, DA,    32'hCAFE_F00D,  1'b1, 1'b0, 4'hF, DA,    32'hCAFE_F00D,  1'b0, 32'h0,          1'b0, 32'h0,          1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b0, 32'h0,          1'b1, 32'h1122_BEEF,  1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, FA,    32'h0,          1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0,          1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, FA,    32'h0,          1'b1, 1'b0, 4'hF, FA,    32'h0,          1'b0, 32'h0,          1'b0, 32'h0,          1'b1};
    vecs[12] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, FA,    32'h0,          1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0,          1'b1};
    vecs[13] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, FA,    32'h0,          1'b1, 1'b0, 4'hF, FA,    32'h0,          1'b0, 32'h0,          1'b0, 32'h0,          1'b1};
    vecs[14] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b0, 32'h0,          1'b1, 32'h3401_1100,  1'b0};
    vecs[15] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, DA,    32'h0,          1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0,          1'b1};
    vecs[16] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, DA,    32'h0,          1'b1, 1'b0, 4'hF, DA,    32'h0,          1'b0, 32'h0,          1'b0, 32'h0,          1'b0};
    vecs[17] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b0, 32'h0,          1'b1, 32'h1122_BEEF,  1'b0};
    vecs[18] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b0, 1'b0, 4'h0, 32'h0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0,          1'b0};

    rst = 1'b1;
    tick();

    for (int i = 0; i < 19; i++) begin
      rst = vecs[i].rst;
      if_req = vecs[i].ifr; if_addr = vecs[i].ifa;
      dm_req = vecs[i].dmr; dm_we = vecs[i].we; dm_sel = vecs[i].sel;
      dm_addr = vecs[i].dma; dm_wdata = vecs[i].wd;
      #1;
      chk($sformatf("v%0d ram_ce", i),    32'(ram_ce),   32'(vecs[i].e_ce));
      chk($sformatf("v%0d ram_we", i),    32'(ram_we),   32'(vecs[i].e_we));
      chk($sformatf("v%0d ram_sel", i),   32'(ram_sel),  32'(vecs[i].e_sel));
      chk($sformatf("v%0d ram_addr", i),  ram_addr,      vecs[i].e_addr);
      chk($sformatf("v%0d ram_wdata", i), ram_wdata,     vecs[i].e_wd);
      chk($sformatf("v%0d if_ack", i),    32'(if_ack),   32'(vecs[i].e_ia));
      chk($sformatf("v%0d if_rdata", i),  if_rdata,      vecs[i].e_ird);
      chk($sformatf("v%0d dm_ack", i),    32'(dm_ack),   32'(vecs[i].e_da));
      chk($sformatf("v%0d dm_rdata", i),  dm_rdata,      vecs[i].e_drd);
      chk($sformatf("v%0d stall_req", i), 32'(stall_req), 32'(vecs[i].e_st));
      tick();
    end

    // Contention: three data grants, then the waiting fetch, twice over.
    run_both("both8", 8, 8'b0111_0111);

    // Fetch alone, held through four acks: back-to-back every two cycles.
    if_req = 1'b1; if_addr = FA; dm_req = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      #1;
      chk($sformatf("fetch4 if_ack c%0d", c), 32'(if_ack),
          32'(c == 2 || c == 4 || c == 6 || c == 8));
      chk($sformatf("fetch4 dm_ack c%0d", c), 32'(dm_ack), 32'h0);
      if (if_ack) chk($sformatf("fetch4 if_rdata c%0d", c), if_rdata, 32'h3401_1100);
      if (c == 8) if_req = 1'b0;
      tick();
    end

    // Run counter must be back at zero: full data run precedes the fetch again.
    run_both("both4", 4, 8'b0000_0111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
